// File: rtl/load_store_unit.sv
// Multi-cycle data-memory interface: turns a core load/store into a req/ack
// bus transaction with byte-lane steering, load extension and misalignment detection.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              MemRW,
  input  logic [1:0]        WSel,
  input  logic [2:0]        RSel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q, state_d;
  size_t       size;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [2:0]  rsel_q;
  logic [1:0]  off_q;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  // Access size comes from WSel for stores and RSel for loads.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    size = SZ_WORD;
    if (MemRW) begin
      case (WSel)
        2'b00:   size = SZ_BYTE;
        2'b01:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (RSel)
        3'b000, 3'b100: size = SZ_BYTE;
        3'b010, 3'b101: size = SZ_HALF;
        default:        size = SZ_WORD;
      endcase
    end
  end

  assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    case (size)
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting uses the lane offset and type captured at issue time.
  always_comb begin
    byte_lane = bus_rdata[{off_q, 3'b000} +: 8];
    half_lane = bus_rdata[{off_q[1], 4'b0000} +: 16];
    case (rsel_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {24'h0, byte_lane};
      3'b010:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_en) state_d = misaligned ? DONE : ACCESS;
      ACCESS:  if (bus_ack) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata     <= '0;
      misalign  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      rsel_q    <= '0;
      off_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_en) begin
            if (misaligned) begin
              misalign <= 1'b1;
              rdata    <= '0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= MemRW;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= MemRW ? be_d : 4'b0000;
              bus_wdata <= wdata_d;
              rsel_q    <= RSel;
              off_q     <= addr[1:0];
            end
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'b0000;
            if (!bus_we) rdata <= load_data;
          end
        end
        default: misalign <= 1'b0;
      endcase
    end
  end

  assign stall = rst_n && mem_en && (state_q != DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores compared against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic        MemRW;
  logic [1:0]  WSel;
  logic [2:0]  RSel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .MemRW(MemRW), .WSel(WSel),
    .RSel(RSel), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  // Runs one memory instruction starting just after a rising edge; returns just after
  // the edge that leaves DONE with mem_en still asserted (caller decides what follows).
  task automatic do_op(input bit st, input logic [1:0] ws, input logic [2:0] rs,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly);
    int          sz, off, stall_n, req_n, unstable;
    bit          mis, done;
    logic [31:0] exp_be, exp_wd, exp_rd, exp_addr, v;
    int          exp_stall, exp_req;

    if (st) sz = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : 4;
    else    sz = (rs == 3'd0 || rs == 3'd4) ? 1 : (rs == 3'd2 || rs == 3'd5) ? 2 : 4;
    off      = int'(a % 4);
    mis      = (int'(a % 32'(sz)) != 0);
    exp_addr = a - 32'(off);
    if (!st)          exp_be = 0;
    else if (sz == 1) exp_be = 32'd1 << off;
    else if (sz == 2) exp_be = 32'd3 << ((off / 2) * 2);
    else              exp_be = 32'd15;
    if (sz == 1)      exp_wd = (wd & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
    else              exp_wd = wd;
    if (sz == 1) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (rs == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (rs == 3'd2 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else v = rd;
    exp_rd    = mis ? 32'd0 : v;
    exp_stall = mis ? 1 : 2 + dly;
    exp_req   = mis ? 0 : 1 + dly;

    mem_en = 1'b1; MemRW = st; WSel = ws; RSel = rs; addr = a; wdata = wd; bus_ack = 1'b0;
    done = 0; stall_n = 0; req_n = 0; unstable = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (bus_req) begin
        req_n++;
        if (bus_addr !== exp_addr || bus_we !== st || bus_be !== exp_be[3:0] ||
            (st && bus_wdata !== exp_wd)) unstable++;
        if (req_n > dly) begin bus_ack = 1'b1; bus_rdata = rd; end
        else begin bus_ack = 1'b0; bus_rdata = $urandom; end
      end else begin
        bus_ack   = 1'($urandom_range(1));  // noise: must be ignored outside ACCESS
        bus_rdata = $urandom;
      end
      if (!stall) begin
        done = 1;
        n_cmp++; if (stall_n !== exp_stall) begin n_err++;
          $display("FAIL stall_cycles addr=%h got %0d exp %0d", a, stall_n, exp_stall); end
        n_cmp++; if (req_n !== exp_req) begin n_err++;
          $display("FAIL req_cycles addr=%h got %0d exp %0d", a, req_n, exp_req); end
        n_cmp++; if (unstable !== 0) begin n_err++;
          $display("FAIL bus_fields addr=%h bad_cycles %0d exp 0 (addr %h be %b wd %h exp %h %b %h)",
                   a, unstable, bus_addr, bus_be, bus_wdata, exp_addr, exp_be[3:0], exp_wd); end
        n_cmp++; if (misalign !== mis) begin n_err++;
          $display("FAIL misalign addr=%h got %b exp %b", a, misalign, mis); end
        if (!st || mis) begin
          n_cmp++; if (rdata !== exp_rd) begin n_err++;
            $display("FAIL rdata addr=%h rsel=%0d got %h exp %h", a, rs, rdata, exp_rd); end
        end
        n_cmp++; if ({bus_req, bus_we, bus_be} !== 6'b0) begin n_err++;
          $display("FAIL done_bus_idle req/we/be got %b%b%b exp 0", bus_req, bus_we, bus_be); end
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL timeout addr=%h no DONE within 40 cycles", a);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  task automatic idle_cycle();
    mem_en = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_en = 1'b1; MemRW = 1'b0; RSel = 3'd3; addr = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_cmp++; if ({bus_req, bus_we, misalign, bus_be} !== 7'b0) begin n_err++;
      $display("FAIL reset_flags req/we/mis/be got %b%b%b%b exp 0", bus_req, bus_we, misalign, bus_be); end
    n_cmp++; if ({rdata, bus_addr, bus_wdata} !== 96'b0) begin n_err++;
      $display("FAIL reset_data rdata %h addr %h wdata %h exp 0", rdata, bus_addr, bus_wdata); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_byte();
    do_op(1'b1, 2'b00, 3'd0, 32'h1003, 32'hAABB_CCDD, 32'h0, 0); idle_cycle();
  endtask

  task automatic test_load_ext();
    do_op(1'b0, 2'b00, 3'b000, 32'h2001, 32'h0, 32'h1234_F6AA, 0); idle_cycle();
    do_op(1'b0, 2'b00, 3'b100, 32'h2001, 32'h0, 32'h1234_F6AA, 0); idle_cycle();
    do_op(1'b0, 2'b00, 3'b010, 32'h2002, 32'h0, 32'h8001_7FFF, 1); idle_cycle();
    do_op(1'b0, 2'b00, 3'b101, 32'h2002, 32'h0, 32'h8001_7FFF, 0); idle_cycle();
  endtask

  task automatic test_wait_states();
    do_op(1'b0, 2'b00, 3'b011, 32'h3000, 32'h0, 32'hDEAD_BEEF, 4); idle_cycle();
  endtask

  task automatic test_misaligned();
    do_op(1'b1, 2'b10, 3'd0, 32'h3002, 32'h1234_5678, 32'h0, 0);
    mem_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (misalign !== 1'b0 || stall !== 1'b0) begin n_err++;
      $display("FAIL misalign_clear mis %b stall %b exp 0 0", misalign, stall); end
    @(posedge clk); #1;
    do_op(1'b0, 2'b00, 3'b101, 32'h3001, 32'h0, 32'h0, 0); idle_cycle();
  endtask

  task automatic test_reset_mid_access();
    mem_en = 1'b1; MemRW = 1'b0; RSel = 3'b011; addr = 32'h3000; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_req_up got %b exp 1", bus_req); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus_req, stall, bus_we, bus_be} !== 7'b0 || bus_addr !== 32'h0) begin n_err++;
      $display("FAIL rst_mid_outputs req %b stall %b we %b be %b addr %h exp 0",
               bus_req, stall, bus_we, bus_be, bus_addr); end
    rst_n = 1'b1; mem_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin n_err++;
      $display("FAIL rst_mid_late_ack req %b stall %b rdata %h exp 0 0 0", bus_req, stall, rdata); end
    bus_ack = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 2'b00, 3'b011, 32'h3004, 32'h0, 32'hCAFE_F00D, 1); idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 2'b01, 3'd0, 32'h4002, 32'h1111_BEEF, 32'h0, 0);
    do_op(1'b0, 2'b00, 3'b000, 32'h4003, 32'h0, 32'h80FF_0102, 2);
    do_op(1'b1, 2'b11, 3'd0, 32'h4008, 32'h0BAD_CAFE, 32'h0, 0);
    idle_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      do_op(1'($urandom_range(1)), 2'($urandom_range(3)), 3'($urandom_range(7)),
            $urandom, $urandom, $urandom, int'($urandom_range(3)));
      if ($urandom_range(1) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; MemRW = 1'b0; WSel = 2'b00; RSel = 3'b000;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_store_byte();
    test_load_ext();
    test_wait_states();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
